imem_loader: RTL and testbench
==============================

# imem_loader

Program loader writing into the byte-addressed, big-endian instruction memory of the MIPS core. It accepts 32-bit instruction words over a valid/ready stream and writes each as four sequential byte writes, so that a later 4-byte read at the word address returns the word unchanged. It holds the CPU off while a program is loading, and reports completion or address overflow.

## Interface
- BASE_ADDR, 0: byte address of the first word written.
- DEPTH, 1024: instruction memory size in bytes; writes must stay below it.
- COUNT_W, 16: width of word_count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load session; sampled only in IDLE.
- in_valid  in  1  in_data holds a valid word.
- in_data  in  32  instruction word.
- in_last  in  1  marks the final word; qualified by in_valid.
- in_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  32  byte address for the write.
- mem_wdata  out  8  byte to write.
- cpu_hold  out  1  CPU must stall; high from start until done or err.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  one-cycle pulse after the last byte of the in_last word is written.
- err  out  1  sticky overflow flag; cleared by the next accepted start.
- word_count  out  COUNT_W  words fully written this session; wraps modulo 2^COUNT_W.

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE: in_ready=0, mem_we=0. When start=1: addr←BASE_ADDR, word_count←0, err←0, cpu_hold←1, go to LOAD.
- LOAD: in_ready=1.
  - On in_valid && in_ready, check for overflow first: if addr+3 ≥ DEPTH, no write occurs; go to ERR.
  - Otherwise latch in_data and in_last, set byte_idx←0, and go to WRITE.
- WRITE: in_ready=0 and mem_we=1 for exactly 4 cycles.
  - mem_addr = addr+byte_idx.
  - mem_wdata = word[31-8·byte_idx -: 8]: the MSB goes to the lowest address.
  - byte_idx counts 0..3.
  - After byte 3: addr←addr+4 and word_count←word_count+1; then go to DONE if the latched last=1, else back to LOAD.
- DONE: done=1 for one cycle, cpu_hold←0, then go to IDLE.
- ERR: err=1 and cpu_hold←0, then go to IDLE. err stays 1 until the next start.
- start outside IDLE is ignored. in_last on a word that is not accepted has no effect.
- Address arithmetic is 32-bit unsigned. The overflow check uses the word's base address before the write.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0, word_count=0; state=IDLE.
- All outputs are registered except in_ready, which is decoded from the state.
- start sampled at edge T: LOAD (in_ready=1) from cycle T+1.
- Word accepted at edge N: byte writes occur in cycles N+1..N+4.
- Next word accepted no earlier than edge N+5, giving a peak throughput of 1 word per 5 cycles.
- done is high in the cycle after the 4th byte write. cpu_hold falls in the same cycle.
- Overflow on an accept at edge N: err=1 from cycle N+1; mem_we never asserts for that word.
- Reset mid-WRITE: mem_we drops immediately (asynchronously). Bytes of the partial word already written remain in memory. The session is abandoned.
- in_valid held high in WRITE: no acceptance occurs, and the data must be held until in_ready=1.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Adds output port checksum (out, 32): the modulo-2^32 sum of all words accepted and written this session.
  - Cleared on an accepted start.
  - Updated in the same cycle word_count increments.
  - Held after DONE and ERR.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then start, then one word 0x8C220004 with in_last=1 -> writes 8C/22/00/04 at addresses 0..3 in 4 consecutive cycles; done pulse in the 5th cycle; word_count=1; cpu_hold low afterwards.
- Three words 0x01234567, 0x89ABCDEF, 0xDEADBEEF (last), in_valid held high -> in_ready high only 1 cycle in 5; bytes at 0..11 read back as the three words; word_count=3.
- BASE_ADDR=1020, DEPTH=1024, two words -> first word written at 1020..1023; second accept sets err; no mem_we with addr ≥ 1024; cpu_hold drops.
- rst_n asserted during the 2nd byte write -> mem_we and all outputs go to 0 immediately; a subsequent start restarts at BASE_ADDR with word_count=0.
- start pulsed during WRITE, and in_last asserted while in_ready=0 -> both ignored; session continues normally.
- With IMEM_LOADER_CHECKSUM_EN: words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 after DONE; a new start clears it to 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: word stream into the loader plus the byte-wide write port
// toward the instruction memory. The loader uses the slave modport; the
// agent feeding words and observing memory writes uses the master modport.
interface imem_loader_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-addressed,
// big-endian instruction memory as four byte writes (MSB at the lowest
// address), holding the CPU off while a load session is in progress.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a 32-bit running
// sum of all words written in the session on output port checksum.
module imem_loader #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    imem_loader_if.slave       bus,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]        checksum,
`endif
    output logic [COUNT_W-1:0] word_count
);

    localparam logic [31:0] BASE_L  = 32'(BASE_ADDR);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    logic        last_q;
    logic        accept;
    logic        overflow;
    logic [31:0] last_byte_addr;
    logic [1:0]  next_idx;

    // Big-endian byte lane select: index 0 is the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign bus.in_ready   = (state == S_LOAD);
    assign accept         = bus.in_valid && (state == S_LOAD);
    // The whole word must fit: its last byte address is checked before any write.
    assign last_byte_addr = addr + 32'd3;
    assign overflow       = (last_byte_addr >= DEPTH_L);
    assign next_idx       = byte_idx + 2'd1;

    // Word capture: only data, so no reset is needed; valid on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= bus.in_data;
            last_q <= bus.in_last;
        end
    end

    // Session FSM with registered outputs; byte 0 is driven straight from
    // in_data at the accept edge so the four writes follow back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            byte_idx      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            word_count    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= BASE_L;
                        word_count <= '0;
                        err        <= 1'b0;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (overflow) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_ERR;
                        end else begin
                            byte_idx      <= 2'd0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= addr;
                            bus.mem_wdata <= byte_sel(bus.in_data, 2'd0);
                            state         <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (byte_idx == 2'd3) begin
                        bus.mem_we <= 1'b0;
                        addr       <= addr + 32'd4;
                        word_count <= word_count + COUNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum   <= checksum + word_q;
`endif
                        if (last_q) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            state    <= S_LOAD;
                        end
                    end else begin
                        byte_idx      <= next_idx;
                        bus.mem_addr  <= addr + {30'd0, next_idx};
                        bus.mem_wdata <= byte_sel(word_q, next_idx);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. One instance loads from
// address 0, a second one starts near the top of memory to exercise the
// overflow path. A byte-array memory behind each instance is read back
// as big-endian words.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic cpu_hold_a, busy_a, done_a, err_a;
    logic cpu_hold_b, busy_b, done_b, err_b;
    logic [15:0] wc_a, wc_b;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cs_a, cs_b;
`endif

    imem_loader_if ifa ();
    imem_loader_if ifb ();

    imem_loader #(.BASE_ADDR(0), .DEPTH(1024), .COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifa),
        .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .err(err_a),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum(cs_a),
`endif
        .word_count(wc_a)
    );

    imem_loader #(.BASE_ADDR(1020), .DEPTH(1024), .COUNT_W(16)) u_ovf (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(ifb),
        .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .err(err_b),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum(cs_b),
`endif
        .word_count(wc_b)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:1023];
    int bad_wr_b = 0;

    // Instruction memory models behind each loader.
    always @(posedge clk) begin
        if (ifa.mem_we && ifa.mem_addr < 32'd1024) mem_a[ifa.mem_addr[9:0]] <= ifa.mem_wdata;
        if (ifb.mem_we) begin
            if (ifb.mem_addr < 32'd1024) mem_b[ifb.mem_addr[9:0]] <= ifb.mem_wdata;
            else bad_wr_b <= bad_wr_b + 1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_a(input int a);
        return {mem_a[a], mem_a[a+1], mem_a[a+2], mem_a[a+3]};
    endfunction

    function automatic logic [31:0] rd_b(input int a);
        return {mem_b[a], mem_b[a+1], mem_b[a+2], mem_b[a+3]};
    endfunction

    // Present one word on instance A and return in the first write cycle.
    task automatic send_word(input logic [31:0] d, input logic last);
        int n = 0;
        ifa.in_valid = 1'b1;
        ifa.in_data  = d;
        ifa.in_last  = last;
        while (!ifa.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait", {31'd0, ifa.in_ready}, 32'd1);
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    // Return in the cycle where done is high on instance A (bounded).
    task automatic wait_done();
        int n = 0;
        while (!done_a && n < 12) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, done_a}, 32'd1);
    endtask

    logic [31:0] w3 [0:2];
    logic [7:0]  exp_b [0:3];
    int acc_cyc [0:2];

    initial begin
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0;
        w3[0] = 32'h01234567; w3[1] = 32'h89ABCDEF; w3[2] = 32'hDEADBEEF;
        exp_b[0] = 8'h8C; exp_b[1] = 8'h22; exp_b[2] = 8'h00; exp_b[3] = 8'h04;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", {31'd0, ifa.in_ready}, 32'd0);
        chk("rst_mem_we",   {31'd0, ifa.mem_we},   32'd0);
        chk("rst_mem_addr", ifa.mem_addr,          32'd0);
        chk("rst_wdata",    {24'd0, ifa.mem_wdata}, 32'd0);
        chk("rst_hold",     {31'd0, cpu_hold_a},   32'd0);
        chk("rst_busy",     {31'd0, busy_a},       32'd0);
        chk("rst_done",     {31'd0, done_a},       32'd0);
        chk("rst_err",      {31'd0, err_a},        32'd0);
        chk("rst_count",    {16'd0, wc_a},         32'd0);
        rst_n = 1'b1;

        // Single word 0x8C220004 with in_last
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("load_ready", {31'd0, ifa.in_ready}, 32'd1);
        chk("load_hold",  {31'd0, cpu_hold_a},   32'd1);
        chk("load_busy",  {31'd0, busy_a},       32'd1);
        send_word(32'h8C220004, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("w1_we",    {31'd0, ifa.mem_we},    32'd1);
            chk("w1_addr",  ifa.mem_addr,           k);
            chk("w1_byte",  {24'd0, ifa.mem_wdata}, {24'd0, exp_b[k]});
            chk("w1_ready", {31'd0, ifa.in_ready},  32'd0);
            tick();
        end
        chk("w1_done",  {31'd0, done_a},     32'd1);
        chk("w1_hold",  {31'd0, cpu_hold_a}, 32'd0);
        chk("w1_we_lo", {31'd0, ifa.mem_we}, 32'd0);
        chk("w1_count", {16'd0, wc_a},       32'd1);
        chk("w1_mem",   rd_a(0),             32'h8C220004);
        tick();
        chk("w1_done_pulse", {31'd0, done_a},     32'd0);
        chk("w1_hold_after", {31'd0, cpu_hold_a}, 32'd0);

        // Three words with in_valid held high
        begin
            int idx = 0;
            int cyc = 0;
            int rdy = 0;
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            ifa.in_valid = 1'b1;
            ifa.in_data  = w3[0];
            ifa.in_last  = 1'b0;
            while (idx < 3 && cyc < 40) begin
                if (ifa.in_ready) begin
                    rdy++;
                    acc_cyc[idx] = cyc;
                    idx++;
                end
                tick();
                cyc++;
                if (idx < 3) begin
                    ifa.in_data = w3[idx];
                    ifa.in_last = (idx == 2);
                end else begin
                    ifa.in_valid = 1'b0;
                    ifa.in_last  = 1'b0;
                end
            end
            chk("w3_accepts", idx, 32'd3);
            while (!done_a && cyc < 60) begin
                if (ifa.in_ready) rdy++;
                tick();
                cyc++;
            end
            chk("w3_done",    {31'd0, done_a}, 32'd1);
            chk("w3_ready_n", rdy, 32'd3);
            chk("w3_gap01",   acc_cyc[1] - acc_cyc[0], 32'd5);
            chk("w3_gap12",   acc_cyc[2] - acc_cyc[1], 32'd5);
            chk("w3_count",   {16'd0, wc_a}, 32'd3);
            chk("w3_mem0",    rd_a(0), 32'h01234567);
            chk("w3_mem4",    rd_a(4), 32'h89ABCDEF);
            chk("w3_mem8",    rd_a(8), 32'hDEADBEEF);
        end
        tick();

        // start pulsed and in_last raised while the loader is writing
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_word(32'h11223344, 1'b0);
        start_a = 1'b1;
        ifa.in_last = 1'b1;
        tick();
        start_a = 1'b0;
        chk("ign_addr", ifa.mem_addr, 32'd1);
        tick();
        ifa.in_last = 1'b0;
        tick(); tick();
        chk("ign_done",  {31'd0, done_a},       32'd0);
        chk("ign_hold",  {31'd0, cpu_hold_a},   32'd1);
        chk("ign_ready", {31'd0, ifa.in_ready}, 32'd1);
        chk("ign_count", {16'd0, wc_a},         32'd1);
        send_word(32'h55667788, 1'b1);
        chk("ign_addr2", ifa.mem_addr, 32'd4);
        wait_done();
        chk("ign_count2", {16'd0, wc_a}, 32'd2);
        chk("ign_mem0",   rd_a(0), 32'h11223344);
        chk("ign_mem4",   rd_a(4), 32'h55667788);
        tick();

        // Reset during the second byte write
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_word(32'hCAFEF00D, 1'b1);
        tick();
        chk("mid_we",   {31'd0, ifa.mem_we}, 32'd1);
        chk("mid_addr", ifa.mem_addr,        32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we",    {31'd0, ifa.mem_we},    32'd0);
        chk("arst_addr",  ifa.mem_addr,           32'd0);
        chk("arst_wdata", {24'd0, ifa.mem_wdata}, 32'd0);
        chk("arst_hold",  {31'd0, cpu_hold_a},    32'd0);
        chk("arst_busy",  {31'd0, busy_a},        32'd0);
        chk("arst_count", {16'd0, wc_a},          32'd0);
        tick();
        chk("arst_byte0", {24'd0, mem_a[0]}, 32'h000000CA);
        chk("arst_byte1", {24'd0, mem_a[1]}, 32'h00000022);
        rst_n = 1'b1;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("rs_count0", {16'd0, wc_a}, 32'd0);
        send_word(32'h0BADBEEF, 1'b1);
        chk("rs_addr",  ifa.mem_addr,           32'd0);
        chk("rs_byte",  {24'd0, ifa.mem_wdata}, 32'h0000000B);
        wait_done();
        chk("rs_count", {16'd0, wc_a}, 32'd1);
        chk("rs_mem",   rd_a(0), 32'h0BADBEEF);
        tick();

        // Overflow near the top of memory
        begin
            int n = 0;
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            ifb.in_valid = 1'b1;
            ifb.in_data  = 32'hA1B2C3D4;
            ifb.in_last  = 1'b0;
            chk("ovf_ready", {31'd0, ifb.in_ready}, 32'd1);
            tick();
            chk("ovf_addr0", ifb.mem_addr, 32'd1020);
            ifb.in_data = 32'h12345678;
            ifb.in_last = 1'b1;
            while (!ifb.in_ready && n < 20) begin
                tick();
                n++;
            end
            chk("ovf_accept2", {31'd0, ifb.in_ready}, 32'd1);
            tick();
            ifb.in_valid = 1'b0;
            ifb.in_last  = 1'b0;
            chk("ovf_err",   {31'd0, err_b},      32'd1);
            chk("ovf_hold",  {31'd0, cpu_hold_b}, 32'd0);
            chk("ovf_we",    {31'd0, ifb.mem_we}, 32'd0);
            chk("ovf_count", {16'd0, wc_b},       32'd1);
            chk("ovf_mem",   rd_b(1020),          32'hA1B2C3D4);
            tick(); tick();
            chk("ovf_sticky", {31'd0, err_b}, 32'd1);
            chk("ovf_no_hi",  bad_wr_b,       32'd0);
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            chk("ovf_clear", {31'd0, err_b},      32'd0);
            chk("ovf_hold2", {31'd0, cpu_hold_b}, 32'd1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Running checksum wraps modulo 2^32 and clears on start
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_word(32'hFFFFFFFF, 1'b0);
        send_word(32'h00000002, 1'b1);
        wait_done();
        chk("cs_sum", cs_a, 32'h00000001);
        tick(); tick();
        chk("cs_held", cs_a, 32'h00000001);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("cs_clear", cs_a, 32'h00000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
